// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter and its sequence monitor.
//   COUNT_W     : width of the counter value bus
//   mon_state_t : monitor FSM states (SYNC = hunting for 0, TRACK = locked)
package counter_pkg;

    localparam int unsigned COUNT_W = 4;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

endpackage : counter_pkg

// File: rtl/count_seq_monitor_sat_counter.sv
// Event counter with synchronous clear; optionally saturates at all-ones.
//   clk, rst : clock, async active-high reset
//   inc      : count one event this cycle
//   clr      : synchronous clear, wins over inc
//   q        : registered count
module sat_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // Hold at all-ones when saturating, otherwise wrap silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            if (!(SATURATE && (&q))) begin
                q <= q + WIDTH'(1);
            end
        end
    end

endmodule : sat_counter

// File: rtl/count_seq_monitor.sv
// Sequence checker for the 0..MAX_COUNT modulo counter: locks on 0, pulses
// and counts wraps, flags out-of-sequence / out-of-range values.
//   clk, rst     : clock, async active-high reset
//   count_i      : counter value, sampled every rising edge
//   clear_i      : sync clear of wrap_cnt_o, err_cnt_o, seq_err_o
//   locked_o     : high while tracking
//   wrap_pulse_o : one-cycle pulse per MAX_COUNT->0 wrap
//   wrap_cnt_o   : wrap count, modulo 2^WRAP_W
//   err_pulse_o  : one-cycle pulse per sequence error
//   seq_err_o    : sticky error flag
//   err_cnt_o    : saturating error count
module count_seq_monitor
    import counter_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 13,
    parameter int unsigned WRAP_W    = 8,
    parameter int unsigned ERR_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_i,
    input  logic               clear_i,
    output logic               locked_o,
    output logic               wrap_pulse_o,
    output logic [WRAP_W-1:0]  wrap_cnt_o,
    output logic               err_pulse_o,
    output logic               seq_err_o,
    output logic [ERR_W-1:0]   err_cnt_o
);

    localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

    mon_state_t         state_q, state_d;
    logic [COUNT_W-1:0] prev_q, prev_d;
    logic [COUNT_W-1:0] exp_val;
    logic               wrap_ev, err_ev;

    // State, prev and one-cycle flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SYNC;
            prev_q       <= '0;
            locked_o     <= 1'b0;
            wrap_pulse_o <= 1'b0;
            err_pulse_o  <= 1'b0;
            seq_err_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            locked_o     <= (state_d == TRACK);
            wrap_pulse_o <= wrap_ev;
            err_pulse_o  <= err_ev;
            if (clear_i) begin
                seq_err_o <= 1'b0;
            end else if (err_ev) begin
                seq_err_o <= 1'b1;
            end
        end
    end

    // Next-state and event decode.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        wrap_ev = 1'b0;
        err_ev  = 1'b0;
        exp_val = (prev_q == MAX_VAL) ? '0 : prev_q + COUNT_W'(1);

        unique case (state_q)
            SYNC: begin
                if (count_i == '0) begin
                    state_d = TRACK;
                    prev_d  = '0;
                end
            end
            TRACK: begin
                // Range check catches values above MAX_COUNT even when they
                // would equal prev+1.
                if ((count_i == exp_val) && (count_i <= MAX_VAL)) begin
                    prev_d  = count_i;
                    wrap_ev = (prev_q == MAX_VAL);
                end else begin
                    err_ev  = 1'b1;
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    sat_counter #(
        .WIDTH    (WRAP_W),
        .SATURATE (1'b0)
    ) u_wrap_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wrap_ev),
        .clr (clear_i),
        .q   (wrap_cnt_o)
    );

    sat_counter #(
        .WIDTH    (ERR_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_ev),
        .clr (clear_i),
        .q   (err_cnt_o)
    );

endmodule : count_seq_monitor

// File: tb/tb_count_seq_monitor.sv
// Directed self-checking bench for count_seq_monitor (MAX_COUNT=13).
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_i;
    logic       clear_i;
    logic       locked_o;
    logic       wrap_pulse_o;
    logic [7:0] wrap_cnt_o;
    logic       err_pulse_o;
    logic       seq_err_o;
    logic [3:0] err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    count_seq_monitor #(
        .MAX_COUNT (13),
        .WRAP_W    (8),
        .ERR_W     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .count_i      (count_i),
        .clear_i      (clear_i),
        .locked_o     (locked_o),
        .wrap_pulse_o (wrap_pulse_o),
        .wrap_cnt_o   (wrap_cnt_o),
        .err_pulse_o  (err_pulse_o),
        .seq_err_o    (seq_err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one value, let the edge sample it, settle past the edge.
    task automatic step(input logic [3:0] v, input logic clr);
        count_i = v;
        clear_i = clr;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(locked_o), 0);
        check({tag, "_wpulse"}, 32'(wrap_pulse_o), 0);
        check({tag, "_wcnt"},   32'(wrap_cnt_o), 0);
        check({tag, "_epulse"}, 32'(err_pulse_o), 0);
        check({tag, "_seqerr"}, 32'(seq_err_o), 0);
        check({tag, "_ecnt"},   32'(err_cnt_o), 0);
    endtask

    initial begin
        rst     = 1'b1;
        count_i = 4'd0;
        clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // 1: lock and one full cycle
        step(4'd0, 1'b0);
        check("t1_lock", 32'(locked_o), 1);
        check("t1_nowrap_first0", 32'(wrap_pulse_o), 0);
        for (int i = 1; i <= 13; i++) step(4'(i), 1'b0);
        check("t1_nowrap_13", 32'(wrap_pulse_o), 0);
        step(4'd0, 1'b0);
        check("t1_wrap_pulse", 32'(wrap_pulse_o), 1);
        check("t1_wrap_cnt", 32'(wrap_cnt_o), 1);
        check("t1_seq_err", 32'(seq_err_o), 0);
        step(4'd1, 1'b0);
        check("t1_pulse_one_cycle", 32'(wrap_pulse_o), 0);

        // 2: skip 5 -> 7
        for (int i = 2; i <= 5; i++) step(4'(i), 1'b0);
        check("t2_no_err_yet", 32'(err_pulse_o), 0);
        step(4'd7, 1'b0);
        check("t2_err_pulse", 32'(err_pulse_o), 1);
        check("t2_seq_err", 32'(seq_err_o), 1);
        check("t2_err_cnt", 32'(err_cnt_o), 1);
        check("t2_unlocked", 32'(locked_o), 0);
        step(4'd8, 1'b0);
        check("t2_err_pulse_off", 32'(err_pulse_o), 0);
        check("t2_sync_wait", 32'(locked_o), 0);
        step(4'd0, 1'b0);
        check("t2_relock", 32'(locked_o), 1);

        // 3: clear, then range error and stall error
        step(4'd1, 1'b1);
        check("t3_clr_ecnt", 32'(err_cnt_o), 0);
        check("t3_clr_seqerr", 32'(seq_err_o), 0);
        check("t3_clr_keep_lock", 32'(locked_o), 1);
        for (int i = 2; i <= 13; i++) step(4'(i), 1'b0);
        step(4'd14, 1'b0);
        check("t3_range_err", 32'(err_pulse_o), 1);
        check("t3_range_cnt", 32'(err_cnt_o), 1);
        step(4'd0, 1'b0);
        for (int i = 1; i <= 3; i++) step(4'(i), 1'b0);
        check("t3_no_err_3", 32'(err_pulse_o), 0);
        step(4'd3, 1'b0);
        check("t3_stall_err", 32'(err_pulse_o), 1);
        check("t3_err_cnt2", 32'(err_cnt_o), 2);

        // 4: saturation and wrap-around
        for (int i = 0; i < 20; i++) begin
            step(4'd0, 1'b0);
            step(4'd5, 1'b0);
        end
        check("t4_err_sat", 32'(err_cnt_o), 15);
        // Erroring 0 must not relock in the same cycle
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        check("t4_zero_err", 32'(err_pulse_o), 1);
        check("t4_zero_no_relock", 32'(locked_o), 0);
        check("t4_err_still_sat", 32'(err_cnt_o), 15);
        step(4'd0, 1'b1);
        check("t4_relock_clr", 32'(locked_o), 1);
        check("t4_clr_ecnt", 32'(err_cnt_o), 0);
        for (int w = 0; w < 257; w++) begin
            for (int i = 1; i <= 13; i++) step(4'(i), 1'b0);
            step(4'd0, 1'b0);
        end
        check("t4_wrap_mod", 32'(wrap_cnt_o), 1);
        check("t4_clean_ecnt", 32'(err_cnt_o), 0);
        check("t4_clean_lock", 32'(locked_o), 1);

        // 5: clear colliding with a wrap
        step(4'd5, 1'b0);
        check("t5_pre_err", 32'(err_cnt_o), 1);
        step(4'd0, 1'b0);
        for (int i = 1; i <= 13; i++) step(4'(i), 1'b0);
        check("t5_pre_wcnt", 32'(wrap_cnt_o), 1);
        step(4'd0, 1'b1);
        check("t5_wpulse", 32'(wrap_pulse_o), 1);
        check("t5_wcnt", 32'(wrap_cnt_o), 0);
        check("t5_ecnt", 32'(err_cnt_o), 0);
        check("t5_seqerr", 32'(seq_err_o), 0);
        check("t5_locked", 32'(locked_o), 1);

        // 6: asynchronous reset between edges
        for (int i = 1; i <= 3; i++) step(4'(i), 1'b0);
        step(4'd9, 1'b0);
        check("t6_pre_err", 32'(seq_err_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        #3;
        rst = 1'b0;
        step(4'd4, 1'b0);
        check("t6_sync_4", 32'(locked_o), 0);
        check("t6_no_err_4", 32'(err_pulse_o), 0);
        check("t6_no_seqerr_4", 32'(seq_err_o), 0);
        step(4'd0, 1'b0);
        check("t6_relock", 32'(locked_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_count_seq_monitor
